// File: rtl/strobe_period_meter_if.sv
// Signal bundle between a strobe source / result consumer (master) and
// strobe_period_meter (slave). WIDTH must match the meter's WIDTH.
interface strobe_period_meter_if #(
  parameter int WIDTH = 20
);
  logic             strobe;
  logic             clear;
  logic [WIDTH-1:0] period;
  logic             period_valid;
  logic             timeout;
  logic             locked;

  modport master (
    output strobe,
    output clear,
    input  period,
    input  period_valid,
    input  timeout,
    input  locked
  );

  modport slave (
    input  strobe,
    input  clear,
    output period,
    output period_valid,
    output timeout,
    output locked
  );
endinterface

// File: rtl/strobe_period_meter.sv
// Measures clk cycles between rising strobe edges, with timeout and lock detection.
// Define STROBE_AVG_EN to report block averages of 2**AVG_LOG2 raw periods.
module strobe_period_meter #(
  parameter int MAX_PERIOD = 1000000,
  parameter int WIDTH      = $clog2(MAX_PERIOD + 1),
  parameter int TOL        = 0,
  parameter int AVG_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  reset_asyn,
  strobe_period_meter_if.slave  bus
);

  if (MAX_PERIOD < 2 || WIDTH < $clog2(MAX_PERIOD + 1) || AVG_LOG2 < 0) begin : g_bad_params
    $error("strobe_period_meter: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    TIMEOUT = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CT_LAST = WIDTH'(MAX_PERIOD - 1);
  localparam logic [WIDTH:0]   TOL_EXT = (WIDTH + 1)'(TOL);

  state_t           state;
  logic             strobe_d;
  logic [WIDTH-1:0] ct;
  logic [WIDTH-1:0] period_q;
  logic             period_valid_q;
  logic             timeout_q;
  logic             locked_q;
  // period_q only serves as the lock reference once a period has been
  // reported since the last reset, clear or timeout.
  logic             have_prev;

  logic             rise;
  logic [WIDTH-1:0] raw_period;
  logic             rpt_fire;
  logic [WIDTH-1:0] rpt_value;
  logic [WIDTH:0]   rpt_diff;
  logic             within_tol;

  assign rise       = bus.strobe & ~strobe_d;
  assign raw_period = ct + WIDTH'(1);

`ifdef STROBE_AVG_EN
  localparam int                 CNT_W    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int                 SUM_W    = WIDTH + AVG_LOG2;
  localparam logic [CNT_W-1:0]   BLK_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_next;
  logic [CNT_W-1:0] blk_cnt;

  assign sum_next  = sum + SUM_W'(raw_period);
  assign rpt_fire  = (blk_cnt == BLK_LAST);
  assign rpt_value = sum_next[SUM_W-1:AVG_LOG2];
`else
  assign rpt_fire  = 1'b1;
  assign rpt_value = raw_period;
`endif

  // Unsigned distance at WIDTH+1 bits so the subtraction can never wrap.
  // NOTE: every variable assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    rpt_diff = '0;
    if (rpt_value >= period_q) begin
      rpt_diff = {1'b0, rpt_value} - {1'b0, period_q};
    end else begin
      rpt_diff = {1'b0, period_q} - {1'b0, rpt_value};
    end
  end

  assign within_tol = (rpt_diff <= TOL_EXT);

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset_asyn) begin
    if (reset_asyn) begin
      state          <= IDLE;
      strobe_d       <= 1'b0;
      ct             <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      locked_q       <= 1'b0;
      have_prev      <= 1'b0;
`ifdef STROBE_AVG_EN
      sum            <= '0;
      blk_cnt        <= '0;
`endif
    end else begin
      strobe_d       <= bus.strobe;
      period_valid_q <= 1'b0;

      if (bus.clear) begin
        // Clear beats a simultaneous edge; the reported period is kept.
        state     <= IDLE;
        ct        <= '0;
        timeout_q <= 1'b0;
        locked_q  <= 1'b0;
        have_prev <= 1'b0;
`ifdef STROBE_AVG_EN
        sum       <= '0;
        blk_cnt   <= '0;
`endif
      end else begin
        unique case (state)
          IDLE: begin
            if (rise) begin
              state <= MEASURE;
              ct    <= '0;
            end
          end

          MEASURE: begin
            if (rise) begin
              ct <= '0;
              if (rpt_fire) begin
                period_q       <= rpt_value;
                period_valid_q <= 1'b1;
                locked_q       <= have_prev & within_tol;
                have_prev      <= 1'b1;
              end
`ifdef STROBE_AVG_EN
              if (rpt_fire) begin
                sum     <= '0;
                blk_cnt <= '0;
              end else begin
                sum     <= sum_next;
                blk_cnt <= blk_cnt + CNT_W'(1);
              end
`endif
            end else if (ct == CT_LAST) begin
              // Strobe lost: ct freezes and lock history is discarded.
              state     <= TIMEOUT;
              timeout_q <= 1'b1;
              locked_q  <= 1'b0;
              have_prev <= 1'b0;
`ifdef STROBE_AVG_EN
              sum       <= '0;
              blk_cnt   <= '0;
`endif
            end else begin
              ct <= ct + WIDTH'(1);
            end
          end

          TIMEOUT: begin
            if (rise) begin
              state     <= MEASURE;
              ct        <= '0;
              timeout_q <= 1'b0;
            end
          end

          default: begin
            state <= IDLE;
            ct    <= '0;
          end
        endcase
      end
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
  assign bus.timeout      = timeout_q;
  assign bus.locked       = locked_q;

endmodule
